// File: rtl/audio_codec_cfg_sequencer.sv
// Walks the fixed WM8731 init table through the I2C register writer, one 24-bit word per handshake.
// Optional feature macro CFG_RETRY_EN: NACKed or timed-out writes are retried up to MAX_RETRY extra times.
module audio_codec_cfg_sequencer #(
    parameter int          NUM_REGS       = 10,
    parameter logic [7:0]  SLAVE_ADDR     = 8'h34,
    parameter logic [15:0] STARTUP_CYCLES = 16'd1000,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd4095,
    parameter int          MAX_RETRY      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        i2c_done,
    input  logic        i2c_ack,
    output logic [23:0] i2c_data,
    output logic        i2c_go,
    output logic [3:0]  cfg_step,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_error
);

`ifdef CFG_RETRY_EN
    localparam logic RETRY_EN = 1'b1;
`else
    localparam logic RETRY_EN = 1'b0;
`endif

    localparam logic [3:0] LAST_STEP = 4'(NUM_REGS - 1);
    localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SETTLE    = 3'd1,
        S_LOAD      = 3'd2,
        S_GO        = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_RELEASE   = 3'd5,
        S_DONE      = 3'd6,
        S_ERROR     = 3'd7
    } state_t;

    // Table word layout is {reg[6:0], data[8:0]}; unused indices read as zero.
    function automatic logic [15:0] cfg_word(input logic [3:0] idx);
        case (idx)
            4'd0:    cfg_word = 16'h0017;
            4'd1:    cfg_word = 16'h0217;
            4'd2:    cfg_word = 16'h0479;
            4'd3:    cfg_word = 16'h0679;
            4'd4:    cfg_word = 16'h0812;
            4'd5:    cfg_word = 16'h0A06;
            4'd6:    cfg_word = 16'h0C00;
            4'd7:    cfg_word = 16'h0E01;
            4'd8:    cfg_word = 16'h1000;
            4'd9:    cfg_word = 16'h1201;
            default: cfg_word = 16'h0000;
        endcase
    endfunction

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [3:0]  r_retry;
    logic        r_nack;
    logic [3:0]  r_step;
    logic [23:0] r_data;
    logic        r_go;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    state_t      w_state_nxt;
    logic [15:0] w_cnt_nxt;
    logic [3:0]  w_retry_nxt;
    logic        w_nack_nxt;
    logic [3:0]  w_step_nxt;
    logic [23:0] w_data_nxt;
    logic        w_go_nxt;
    logic        w_busy_nxt;
    logic        w_done_nxt;
    logic        w_err_nxt;

    // State and registered outputs; i2c_go drops asynchronously with reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 16'd0;
            r_retry <= 4'd0;
            r_nack  <= 1'b0;
            r_step  <= 4'd0;
            r_data  <= 24'h000000;
            r_go    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_retry <= w_retry_nxt;
            r_nack  <= w_nack_nxt;
            r_step  <= w_step_nxt;
            r_data  <= w_data_nxt;
            r_go    <= w_go_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Next-state and next-output decode; r_cnt is shared by settle, timeout and release timing.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_retry_nxt = r_retry;
        w_nack_nxt  = r_nack;
        w_step_nxt  = r_step;
        w_data_nxt  = r_data;
        w_go_nxt    = r_go;
        w_busy_nxt  = r_busy;
        w_done_nxt  = r_done;
        w_err_nxt   = r_err;

        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    w_state_nxt = S_SETTLE;
                    w_cnt_nxt   = 16'd0;
                    w_step_nxt  = 4'd0;
                    w_retry_nxt = 4'd0;
                    w_done_nxt  = 1'b0;
                    w_err_nxt   = 1'b0;
                    w_busy_nxt  = 1'b1;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_SETTLE: begin
                if (r_cnt == (STARTUP_CYCLES - 16'd1)) begin
                    w_state_nxt = S_LOAD;
                    w_cnt_nxt   = 16'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            S_LOAD: begin
                w_data_nxt  = {SLAVE_ADDR, cfg_word(r_step)};
                w_go_nxt    = 1'b1;
                w_cnt_nxt   = 16'd0;
                w_state_nxt = S_GO;
            end
            S_GO: begin
                w_cnt_nxt   = r_cnt + 16'd1;
                w_state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                // A done arriving on the expiry cycle still wins; its ack decides.
                if (i2c_done) begin
                    w_nack_nxt  = i2c_ack;
                    w_go_nxt    = 1'b0;
                    w_cnt_nxt   = 16'd0;
                    w_state_nxt = S_RELEASE;
                end else if (r_cnt == (TIMEOUT_CYCLES - 16'd1)) begin
                    w_nack_nxt  = 1'b1;
                    w_go_nxt    = 1'b0;
                    w_cnt_nxt   = 16'd0;
                    w_state_nxt = S_RELEASE;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            S_RELEASE: begin
                if (!i2c_done && (r_cnt != 16'd0)) begin
                    w_cnt_nxt = 16'd0;
                    if (!r_nack) begin
                        if (r_step == LAST_STEP) begin
                            w_state_nxt = S_DONE;
                            w_done_nxt  = 1'b1;
                            w_busy_nxt  = 1'b0;
                        end else begin
                            w_step_nxt  = r_step + 4'd1;
                            w_retry_nxt = 4'd0;
                            w_state_nxt = S_LOAD;
                        end
                    end else if (RETRY_EN && (r_retry < RETRY_MAX)) begin
                        w_retry_nxt = r_retry + 4'd1;
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_state_nxt = S_ERROR;
                        w_err_nxt   = 1'b1;
                        w_busy_nxt  = 1'b0;
                    end
                end else begin
                    w_cnt_nxt = 16'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_go_nxt    = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign i2c_data  = r_data;
    assign i2c_go    = r_go;
    assign cfg_step  = r_step;
    assign cfg_busy  = r_busy;
    assign cfg_done  = r_done;
    assign cfg_error = r_err;

endmodule

// File: tb/tb_audio_codec_cfg_sequencer.sv
// Directed bench for audio_codec_cfg_sequencer with a behavioural I2C writer responder.
// Expectations adapt to whether CFG_RETRY_EN is defined.
module tb_audio_codec_cfg_sequencer;

`ifdef CFG_RETRY_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    localparam logic [23:0] EXP [10] = '{24'h340017, 24'h340217, 24'h340479, 24'h340679, 24'h340812,
                                         24'h340A06, 24'h340C00, 24'h340E01, 24'h341000, 24'h341201};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        i2c_done;
    logic        i2c_ack;
    logic [23:0] i2c_data;
    logic        i2c_go;
    logic [3:0]  cfg_step;
    logic        cfg_busy;
    logic        cfg_done;
    logic        cfg_error;

    int n_tests = 0;
    int n_fail  = 0;

    // Writer model / monitor state
    int          wmode = 0;
    int          wdly = 0;
    bit          nacked_once = 1'b0;
    logic [23:0] log_data [0:31];
    int          log_n = 0;
    int          low_cnt = 0;
    int          min_low = 99;
    int          high_cnt = 0;
    int          last_high = 0;
    int          stab_err = 0;
    logic        prev_go = 1'b0;
    logic [23:0] prev_data = 24'h000000;
    int          lat;

    audio_codec_cfg_sequencer #(
        .NUM_REGS       (10),
        .SLAVE_ADDR     (8'h34),
        .STARTUP_CYCLES (16'd8),
        .TIMEOUT_CYCLES (16'd16),
        .MAX_RETRY      (2)
    ) dut (
        .clk       (clk),
        .reset     (rst_n),
        .start     (start),
        .i2c_done  (i2c_done),
        .i2c_ack   (i2c_ack),
        .i2c_data  (i2c_data),
        .i2c_go    (i2c_go),
        .cfg_step  (cfg_step),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .cfg_error (cfg_error)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Writer responder and bus monitor, all on the falling edge.
    initial begin
        bit nack_v;
        i2c_done = 1'b0;
        i2c_ack  = 1'b0;
        forever begin
            @(negedge clk);
            if (i2c_go && !prev_go) begin
                if (log_n < 32) log_data[log_n] = i2c_data;
                log_n++;
                if (log_n > 1 && low_cnt < min_low) min_low = low_cnt;
                low_cnt  = 0;
                high_cnt = 0;
            end
            if (i2c_go) begin
                high_cnt++;
                if (prev_go && (i2c_data != prev_data)) stab_err++;
            end else begin
                low_cnt++;
                if (prev_go) last_high = high_cnt;
            end
            if (!rst_n) begin
                i2c_done = 1'b0;
                i2c_ack  = 1'b0;
                wdly     = 0;
            end else if (i2c_go && !i2c_done) begin
                if (wmode != 3) begin
                    wdly++;
                    if (wdly >= 3) begin
                        wdly   = 0;
                        nack_v = (wmode == 2 && i2c_data == 24'h340679) ||
                                 (wmode == 1 && i2c_data == 24'h340679 && !nacked_once);
                        if (wmode == 1 && nack_v) nacked_once = 1'b1;
                        i2c_done = 1'b1;
                        i2c_ack  = nack_v;
                    end
                end
            end else if (!i2c_go && i2c_done) begin
                i2c_done = 1'b0;
                i2c_ack  = 1'b0;
            end
            prev_go   = i2c_go;
            prev_data = i2c_data;
        end
    end

    task automatic clear_log();
        log_n       = 0;
        min_low     = 99;
        last_high   = 0;
        nacked_once = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic start_and_time(output int l);
        int n;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        n = 1;
        #1;
        start = 1'b0;
        while (!i2c_go && n < 200) begin
            @(posedge clk);
            n++;
            #1;
        end
        l = n;
    endtask

    task automatic wait_log(input int want, input string tag);
        int k = 0;
        while (log_n < want && k < 2000) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_eq(tag, 32'(log_n >= want), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (cfg_busy && k < 3000) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_eq(tag, 32'(cfg_busy), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_go",    32'(i2c_go),    32'd0);
        check_eq("rst_data",  32'(i2c_data),  32'd0);
        check_eq("rst_step",  32'(cfg_step),  32'd0);
        check_eq("rst_busy",  32'(cfg_busy),  32'd0);
        check_eq("rst_done",  32'(cfg_done),  32'd0);
        check_eq("rst_error", 32'(cfg_error), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full all-ACK sequence, with a start pulse while busy
        wmode = 0;
        clear_log();
        start_and_time(lat);
        check_eq("start_lat", 32'(lat), 32'd10);
        wait_log(4, "wait_word4");
        pulse_start();
        check_eq("busy_ignore", 32'(cfg_busy), 32'd1);
        wait_idle("idle_all_ack");
        check_eq("all_count", 32'(log_n), 32'd10);
        for (int i = 0; i < 10; i++) check_eq($sformatf("word%0d", i), 32'(log_data[i]), 32'(EXP[i]));
        check_eq("all_done",  32'(cfg_done),  32'd1);
        check_eq("all_error", 32'(cfg_error), 32'd0);
        check_eq("all_step",  32'(cfg_step),  32'd9);
        check_eq("min_low",   32'(min_low),   32'd3);

        // Restart from DONE
        clear_log();
        pulse_start();
        check_eq("restart_done_clr", 32'(cfg_done), 32'd0);
        check_eq("restart_busy",     32'(cfg_busy), 32'd1);
        check_eq("restart_step",     32'(cfg_step), 32'd0);
        wait_idle("idle_restart");
        check_eq("restart_count", 32'(log_n),    32'd10);
        check_eq("restart_done",  32'(cfg_done), 32'd1);

        // Entry 3 NACKed once
        clear_log();
        wmode = 1;
        pulse_start();
        wait_idle("idle_nack1");
        check_eq("nack1_count", 32'(log_n),       RB ? 32'd11 : 32'd4);
        check_eq("nack1_word3", 32'(log_data[3]), 32'h340679);
        check_eq("nack1_done",  32'(cfg_done),    RB ? 32'd1 : 32'd0);
        check_eq("nack1_error", 32'(cfg_error),   RB ? 32'd0 : 32'd1);
        check_eq("nack1_step",  32'(cfg_step),    RB ? 32'd9 : 32'd3);
        if (RB) check_eq("nack1_retry_word", 32'(log_data[4]), 32'h340679);

        // Entry 3 NACKed always
        clear_log();
        wmode = 2;
        pulse_start();
        wait_idle("idle_nack_all");
        check_eq("nackall_count", 32'(log_n),             RB ? 32'd6 : 32'd4);
        check_eq("nackall_last",  32'(log_data[log_n-1]), 32'h340679);
        check_eq("nackall_error", 32'(cfg_error),         32'd1);
        check_eq("nackall_done",  32'(cfg_done),          32'd0);
        check_eq("nackall_step",  32'(cfg_step),          32'd3);

        // Writer never answers: timeout
        clear_log();
        wmode = 3;
        pulse_start();
        wait_idle("idle_timeout");
        check_eq("tmo_go_width", 32'(last_high), 32'd16);
        check_eq("tmo_count",    32'(log_n),     RB ? 32'd3 : 32'd1);
        check_eq("tmo_error",    32'(cfg_error), 32'd1);
        check_eq("tmo_step",     32'(cfg_step),  32'd0);

        // Reset during WAIT_DONE of entry 5
        clear_log();
        wmode = 0;
        pulse_start();
        wait_log(6, "wait_word6");
        check_eq("pre_rst_go",   32'(i2c_go),   32'd1);
        check_eq("pre_rst_step", 32'(cfg_step), 32'd5);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_go",    32'(i2c_go),    32'd0);
        check_eq("mid_rst_data",  32'(i2c_data),  32'd0);
        check_eq("mid_rst_step",  32'(cfg_step),  32'd0);
        check_eq("mid_rst_busy",  32'(cfg_busy),  32'd0);
        check_eq("mid_rst_done",  32'(cfg_done),  32'd0);
        check_eq("mid_rst_error", 32'(cfg_error), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        start_and_time(lat);
        check_eq("post_rst_lat", 32'(lat), 32'd10);
        wait_idle("idle_post_rst");
        check_eq("post_rst_count", 32'(log_n),       32'd10);
        check_eq("post_rst_word0", 32'(log_data[0]), 32'h340017);
        check_eq("post_rst_done",  32'(cfg_done),    32'd1);

        check_eq("data_stable", 32'(stab_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_codec_cfg_sequencer.md
# audio_codec_cfg_sequencer

Upstream control stage for the audio codec I2C register writer. Holds the fixed WM8731 register-initialisation table, presents one 24-bit I2C word at a time together with a go strobe, and waits for the writer's completion and acknowledge status. Retries failed writes, then reports overall completion or failure to the audio top level. Runs on the same divided I2C control clock as the writer, so every handshake is synchronous.

## Interface
- `NUM_REGS`, 10: table entries written per sequence (1-16).
- `SLAVE_ADDR`, 8'h34: codec write address, forms i2c_data[23:16].
- `STARTUP_CYCLES`, 16'd1000: power-on settle delay before first write.
- `TIMEOUT_CYCLES`, 16'd4095: maximum wait for i2c_done per transaction.
- `MAX_RETRY`, 2: extra attempts per entry after a failure (retry build only).
- `clk` in 1: I2C control clock.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle request to run the sequence.
- `i2c_done` in 1: writer has finished the current word (level, high until go drops).
- `i2c_ack` in 1: writer's OR-ed acknowledge result; 1 = NACK, sampled with i2c_done.
- `i2c_data` out 24: {SLAVE_ADDR, table word[15:0]}.
- `i2c_go` out 1: transaction request to the writer.
- `cfg_step` out 4: index of entry in progress.
- `cfg_busy` out 1: sequence running.
- `cfg_done` out 1: all entries acknowledged (sticky until next start).
- `cfg_error` out 1: an entry failed permanently (sticky until next start).

## Operation
- Table word = {reg[6:0], data[8:0]}; entries 0-9: 16'h0017, 16'h0217, 16'h0479, 16'h0679, 16'h0812, 16'h0A06, 16'h0C00, 16'h0E01, 16'h1000, 16'h1201. Indices >= NUM_REGS are never read.
- States: IDLE, SETTLE, LOAD, GO, WAIT_DONE, RELEASE, DONE, ERROR.
- IDLE/DONE/ERROR --start--> SETTLE: clear cfg_done, cfg_error, cfg_step, retry count; cfg_busy=1.
- SETTLE: count to STARTUP_CYCLES-1, then LOAD.
- LOAD: register i2c_data from table[cfg_step]; next GO.
- GO: i2c_go=1; stays high through WAIT_DONE.
- WAIT_DONE: on i2c_done=1 sample i2c_ack, drop i2c_go, go to RELEASE. Timeout counter reaching TIMEOUT_CYCLES-1 without i2c_done counts as NACK.
- RELEASE: hold i2c_go=0 until i2c_done=0 and at least 2 cycles have elapsed. Then: ACK and cfg_step==NUM_REGS-1 -> DONE; ACK -> cfg_step+1, retry count cleared, LOAD; NACK -> retry or ERROR (see Configuration).
- DONE: cfg_done=1, cfg_busy=0. ERROR: cfg_error=1, cfg_busy=0, cfg_step frozen at failing entry.
- start while cfg_busy=1: ignored.
- cfg_step is 4 bits, never wraps; it stops at NUM_REGS-1.

## Timing
- Reset values: i2c_go=0, i2c_data=24'h0, cfg_step=0, cfg_busy=0, cfg_done=0, cfg_error=0; state IDLE; all counters 0.
- Reset mid-transaction: i2c_go drops immediately; no resume, next start reruns from entry 0.
- start to first i2c_go rise: STARTUP_CYCLES+2 cycles.
- i2c_data is stable from LOAD through the cycle i2c_go falls; never changes while i2c_go=1.
- i2c_go falls the cycle after i2c_done is sampled high; minimum i2c_go low time between words is 2 cycles, plus LOAD.
- i2c_done and timeout expiring in the same cycle: i2c_done wins, and i2c_ack decides.

## Configuration
- `CFG_RETRY_EN` defined: on NACK or timeout, if retry count < MAX_RETRY, increment it and return to LOAD with the same cfg_step. Otherwise go to ERROR.
- `CFG_RETRY_EN` undefined: any NACK or timeout goes straight to ERROR. MAX_RETRY is unused.

## Test plan
- All ACK, NUM_REGS=10: start -> 10 go/done handshakes with i2c_data 24'h340017 ... 24'h341201 in order -> cfg_done=1, cfg_busy=0, cfg_step=9.
- NACK on entry 3 once, retry build: entry 3 (24'h340679) sent twice, sequence completes, cfg_done=1.
- NACK on entry 3 always, retry build with MAX_RETRY=2: 3 attempts -> cfg_error=1, cfg_step=3. Non-retry build: 1 attempt -> cfg_error=1.
- i2c_done never asserts, TIMEOUT_CYCLES=16: i2c_go drops 16 cycles after rising -> handled as NACK.
- Reset asserted during WAIT_DONE of entry 5: all outputs return to reset values in the same cycle. A following start runs from entry 0 after STARTUP_CYCLES.
- start pulsed while busy -> no effect. start pulsed in DONE -> cfg_done clears and a full sequence reruns.
